// File: rtl/ring_count_decode.sv
// Decodes a captured three-digit Johnson-coded ring counter value into binary, derives the
// modulo-1000 advance since the previous sample, and averages it over a 2^pAVG_LOG2 window.
module ring_count_decode #(
  parameter int unsigned pAVG_LOG2 = 2
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_sample,
  input  logic [4:0] i_100,
  input  logic [4:0] i_010,
  input  logic [4:0] i_001,
  output logic       o_valid,
  output logic [9:0] o_count,
  output logic [9:0] o_delta,
  output logic       o_err,
  output logic       o_avg_valid,
  output logic [9:0] o_avg
);

  localparam int unsigned AccW = 10 + pAVG_LOG2;
  localparam int unsigned CntW = pAVG_LOG2 + 1;
  localparam logic [CntW-1:0] WinLen = CntW'(2 ** pAVG_LOG2);

  // Returns {illegal, bcd}; illegal codes decode to 0.
  function automatic logic [4:0] dec_digit(input logic [4:0] code);
    logic [4:0] res;
    case (code)
      5'b00000: res = 5'd0;
      5'b00001: res = 5'd1;
      5'b00011: res = 5'd2;
      5'b00111: res = 5'd3;
      5'b01111: res = 5'd4;
      5'b11111: res = 5'd5;
      5'b11110: res = 5'd6;
      5'b11100: res = 5'd7;
      5'b11000: res = 5'd8;
      5'b10000: res = 5'd9;
      default:  res = 5'b10000;
    endcase
    return res;
  endfunction

  // S1: raw digit capture
  logic       s1_valid_d, s1_valid_q;
  logic [4:0] s1_h_d, s1_h_q, s1_t_d, s1_t_q, s1_o_d, s1_o_q;
  // S2: decoded BCD
  logic       s2_valid_d, s2_valid_q, s2_err_d, s2_err_q;
  logic [3:0] s2_h_d, s2_h_q, s2_t_d, s2_t_q, s2_o_d, s2_o_q;
  // S3: binary count
  logic       s3_valid_d, s3_valid_q, s3_err_d, s3_err_q;
  logic [9:0] s3_count_d, s3_count_q;
  // S4: delta, averaging and outputs
  logic            prime_d, prime_q;
  logic [9:0]      prev_d, prev_q;
  logic [AccW-1:0] acc_d, acc_q;
  logic [CntW-1:0] win_cnt_d, win_cnt_q;
  logic            valid_d, valid_q, err_d, err_q, avg_valid_d, avg_valid_q;
  logic [9:0]      count_d, count_q, delta_d, delta_q, avg_d, avg_q;

  logic [4:0]      dec_h, dec_t, dec_o;
  logic [9:0]      h_w, t_w, o_w;
  logic [10:0]     cur_w, prev_w;
  logic [9:0]      delta;
  logic [AccW:0]   sum;
  logic [CntW-1:0] cnt_inc;

  always_comb begin
    s1_valid_d = i_sample;
    s1_h_d     = i_100;
    s1_t_d     = i_010;
    s1_o_d     = i_001;
  end

  always_comb begin
    dec_h      = dec_digit(s1_h_q);
    dec_t      = dec_digit(s1_t_q);
    dec_o      = dec_digit(s1_o_q);
    s2_valid_d = s1_valid_q;
    s2_err_d   = s1_valid_q & (dec_h[4] | dec_t[4] | dec_o[4]);
    s2_h_d     = dec_h[3:0];
    s2_t_d     = dec_t[3:0];
    s2_o_d     = dec_o[3:0];
  end

  always_comb begin
    h_w        = {6'd0, s2_h_q};
    t_w        = {6'd0, s2_t_q};
    o_w        = {6'd0, s2_o_q};
    // 100 = 64 + 32 + 4, 10 = 8 + 2
    s3_count_d = (h_w << 6) + (h_w << 5) + (h_w << 2) + (t_w << 3) + (t_w << 1) + o_w;
    s3_valid_d = s2_valid_q;
    s3_err_d   = s2_err_q;
  end

  always_comb begin
    cur_w   = {1'b0, s3_count_q};
    prev_w  = {1'b0, prev_q};
    delta   = (cur_w >= prev_w) ? 10'(cur_w - prev_w) : 10'(cur_w + 11'd1000 - prev_w);
    sum     = (AccW + 1)'(acc_q) + (AccW + 1)'(delta);
    cnt_inc = win_cnt_q + CntW'(1);

    prime_d     = prime_q;
    prev_d      = prev_q;
    acc_d       = acc_q;
    win_cnt_d   = win_cnt_q;
    valid_d     = 1'b0;
    err_d       = 1'b0;
    count_d     = 10'd0;
    delta_d     = 10'd0;
    avg_valid_d = 1'b0;
    avg_d       = avg_q;

    if (s3_valid_q) begin
      if (s3_err_q) begin
        valid_d   = 1'b1;
        err_d     = 1'b1;
        prime_d   = 1'b0;
        acc_d     = '0;
        win_cnt_d = '0;
      end else if (!prime_q) begin
        prime_d = 1'b1;
        prev_d  = s3_count_q;
      end else begin
        valid_d = 1'b1;
        count_d = s3_count_q;
        delta_d = delta;
        prev_d  = s3_count_q;
        if (cnt_inc == WinLen) begin
          avg_valid_d = 1'b1;
          avg_d       = 10'(sum >> pAVG_LOG2);
          acc_d       = '0;
          win_cnt_d   = '0;
        end else begin
          acc_d     = AccW'(sum);
          win_cnt_d = cnt_inc;
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s1_valid_q  <= 1'b0;
      s1_h_q      <= '0;
      s1_t_q      <= '0;
      s1_o_q      <= '0;
      s2_valid_q  <= 1'b0;
      s2_err_q    <= 1'b0;
      s2_h_q      <= '0;
      s2_t_q      <= '0;
      s2_o_q      <= '0;
      s3_valid_q  <= 1'b0;
      s3_err_q    <= 1'b0;
      s3_count_q  <= '0;
      prime_q     <= 1'b0;
      prev_q      <= '0;
      acc_q       <= '0;
      win_cnt_q   <= '0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
      count_q     <= '0;
      delta_q     <= '0;
      avg_valid_q <= 1'b0;
      avg_q       <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_h_q      <= s1_h_d;
      s1_t_q      <= s1_t_d;
      s1_o_q      <= s1_o_d;
      s2_valid_q  <= s2_valid_d;
      s2_err_q    <= s2_err_d;
      s2_h_q      <= s2_h_d;
      s2_t_q      <= s2_t_d;
      s2_o_q      <= s2_o_d;
      s3_valid_q  <= s3_valid_d;
      s3_err_q    <= s3_err_d;
      s3_count_q  <= s3_count_d;
      prime_q     <= prime_d;
      prev_q      <= prev_d;
      acc_q       <= acc_d;
      win_cnt_q   <= win_cnt_d;
      valid_q     <= valid_d;
      err_q       <= err_d;
      count_q     <= count_d;
      delta_q     <= delta_d;
      avg_valid_q <= avg_valid_d;
      avg_q       <= avg_d;
    end
  end

  assign o_valid     = valid_q;
  assign o_count     = count_q;
  assign o_delta     = delta_q;
  assign o_err       = err_q;
  assign o_avg_valid = avg_valid_q;
  assign o_avg       = avg_q;

endmodule

// File: tb/tb_ring_count_decode.sv
// Bench for ring_count_decode: a queue-based sample model checked every cycle, plus
// literal expectations for the prime, wrap, error, average, throughput and reset cases.
module tb_ring_count_decode;
  localparam int unsigned L = 2;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b1;
  logic       i_sample = 1'b0;
  logic [4:0] i_100 = '0, i_010 = '0, i_001 = '0;
  logic       o_valid, o_err, o_avg_valid;
  logic [9:0] o_count, o_delta, o_avg;

  ring_count_decode #(.pAVG_LOG2(L)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_sample(i_sample),
    .i_100(i_100), .i_010(i_010), .i_001(i_001),
    .o_valid(o_valid), .o_count(o_count), .o_delta(o_delta), .o_err(o_err),
    .o_avg_valid(o_avg_valid), .o_avg(o_avg)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  logic [4:0] code_tab [10] = '{5'b00000, 5'b00001, 5'b00011, 5'b00111, 5'b01111,
                                5'b11111, 5'b11110, 5'b11100, 5'b11000, 5'b10000};

  function automatic logic [4:0] enc(input int d);
    return code_tab[d];
  endfunction

  function automatic int dec(input logic [4:0] c);
    for (int i = 0; i < 10; i++) if (code_tab[i] == c) return i;
    return -1;
  endfunction

  // Inputs as seen by the DUT at each rising edge.
  logic       s_rst, s_smp;
  logic [4:0] s_h, s_t, s_o;
  always @(posedge i_clk) begin
    s_rst <= i_rst;
    s_smp <= i_sample;
    s_h   <= i_100;
    s_t   <= i_010;
    s_o   <= i_001;
  end

  typedef struct {
    int         due;
    logic [4:0] h, t, o;
  } samp_t;
  samp_t pend[$];

  int cyc = 0;
  int m_prime = 0, m_prev = 0, m_acc = 0, m_cnt = 0;
  int e_valid = 0, e_err = 0, e_count = 0, e_delta = 0, e_avg_valid = 0, e_avg = 0;
  int n_valid = 0, n_avg = 0, run = 0, max_run = 0;
  int last_count = 0, last_delta = 0, last_err = 0, last_avg = 0;

  // Model step, per-cycle compare and output statistics, once per falling edge.
  initial begin
    forever begin
      @(negedge i_clk);
      cyc++;
      if (s_rst) begin
        pend.delete();
        m_prime = 0; m_prev = 0; m_acc = 0; m_cnt = 0;
        e_valid = 0; e_err = 0; e_count = 0; e_delta = 0; e_avg_valid = 0; e_avg = 0;
      end else begin
        e_valid = 0; e_err = 0; e_count = 0; e_delta = 0; e_avg_valid = 0;
        if (pend.size() > 0 && pend[0].due == cyc) begin
          samp_t s;
          int h, t, o, cur, d;
          s = pend.pop_front();
          h = dec(s.h); t = dec(s.t); o = dec(s.o);
          if (h < 0 || t < 0 || o < 0) begin
            e_valid = 1; e_err = 1;
            m_prime = 0; m_acc = 0; m_cnt = 0;
          end else begin
            cur = 100 * h + 10 * t + o;
            if (m_prime == 0) begin
              m_prime = 1;
              m_prev = cur;
            end else begin
              d = (cur - m_prev + 1000) % 1000;
              e_valid = 1; e_count = cur; e_delta = d;
              m_prev = cur;
              m_acc += d;
              m_cnt++;
              if (m_cnt == (1 << L)) begin
                e_avg_valid = 1;
                e_avg = m_acc >> L;
                m_acc = 0;
                m_cnt = 0;
              end
            end
          end
        end
        if (s_smp) pend.push_back('{cyc + 3, s_h, s_t, s_o});
      end

      check("cyc_valid", o_valid, e_valid);
      check("cyc_err", o_err, e_err);
      check("cyc_avg_valid", o_avg_valid, e_avg_valid);
      check("cyc_avg", o_avg, e_avg);
      if (e_valid != 0) begin
        check("cyc_count", o_count, e_count);
        check("cyc_delta", o_delta, e_delta);
      end

      if (o_valid === 1'b1) begin
        n_valid++;
        last_count = o_count; last_delta = o_delta; last_err = o_err;
        run++;
        if (run > max_run) max_run = run;
      end else begin
        run = 0;
      end
      if (o_avg_valid === 1'b1) begin
        n_avg++;
        last_avg = o_avg;
      end
    end
  end

  task automatic put(input logic s, input int n);
    @(negedge i_clk);
    i_sample = s;
    i_100 = enc(n / 100);
    i_010 = enc((n / 10) % 10);
    i_001 = enc(n % 10);
  endtask

  task automatic idle(input int c);
    repeat (c) begin
      @(negedge i_clk);
      i_sample = 1'b0;
    end
  endtask

  task automatic strobe(input int n);
    put(1'b1, n);
    idle(5);
    #1;
  endtask

  task automatic strobe_raw(input logic [4:0] h, input logic [4:0] t, input logic [4:0] o);
    @(negedge i_clk);
    i_sample = 1'b1; i_100 = h; i_010 = t; i_001 = o;
    idle(5);
    #1;
  endtask

  task automatic do_reset();
    @(negedge i_clk);
    i_rst = 1'b1;
    i_sample = 1'b0;
    @(negedge i_clk);
    i_rst = 1'b0;
  endtask

  task automatic check_outs_zero(input string tag);
    check({tag, "_valid"}, o_valid, 0);
    check({tag, "_count"}, o_count, 0);
    check({tag, "_delta"}, o_delta, 0);
    check({tag, "_err"}, o_err, 0);
    check({tag, "_avg_valid"}, o_avg_valid, 0);
    check({tag, "_avg"}, o_avg, 0);
  endtask

  int v0, a0;

  initial begin
    repeat (3) @(negedge i_clk);
    #1;
    check_outs_zero("rst");
    i_rst = 1'b0;

    // Prime then first delta
    strobe(123);
    check("prime_no_valid", n_valid, 0);
    strobe(130);
    check("prime_n_valid", n_valid, 1);
    check("prime_count", last_count, 130);
    check("prime_delta", last_delta, 7);
    check("prime_err", last_err, 0);

    // Wrap-around and zero delta; window 7+868+7+0 closes
    strobe(998);
    strobe(5);
    check("wrap_delta", last_delta, 7);
    check("wrap_count", last_count, 5);
    strobe(5);
    check("same_delta", last_delta, 0);
    check("win1_n_avg", n_avg, 1);
    check("win1_avg", last_avg, 220);

    // Error then re-prime
    strobe_raw(enc(0), enc(0), 5'b01010);
    check("err_n_valid", n_valid, 5);
    check("err_flag", last_err, 1);
    check("err_delta", last_delta, 0);
    check("err_count", last_count, 0);
    strobe(10);
    check("reprime_no_valid", n_valid, 5);
    strobe(20);
    check("reprime_delta", last_delta, 10);

    // Deltas 10, 11, 12, 14 -> 47 >> 2
    strobe(31);
    strobe(43);
    strobe(57);
    check("avg_n_avg", n_avg, 2);
    check("avg_value", last_avg, 11);

    // Error after two deltas discards the partial window
    strobe(62);
    strobe(67);
    strobe_raw(enc(1), 5'b00101, enc(0));
    strobe(100);
    for (int n = 101; n <= 103; n++) strobe(n);
    check("restart_no_early_avg", n_avg, 2);
    strobe(104);
    check("restart_n_avg", n_avg, 3);
    check("restart_avg", last_avg, 1);

    // Back-to-back strobes 0..20
    do_reset();
    v0 = n_valid;
    a0 = n_avg;
    for (int n = 0; n <= 20; n++) put(1'b1, n);
    idle(6);
    #1;
    check("tput_n_valid", n_valid - v0, 20);
    check("tput_run", max_run, 20);
    check("tput_n_avg", n_avg - a0, 5);
    check("tput_avg", last_avg, 1);
    check("tput_delta", last_delta, 1);

    // Reset one cycle after a strobe drops it
    v0 = n_valid;
    put(1'b1, 500);
    @(negedge i_clk);
    i_sample = 1'b0;
    i_rst = 1'b1;
    @(negedge i_clk);
    i_rst = 1'b0;
    idle(4);
    #1;
    check("midrst_no_valid", n_valid, v0);
    check_outs_zero("midrst");
    strobe(600);
    check("midrst_reprime", n_valid, v0);
    strobe(610);
    check("midrst_delta", last_delta, 10);

    // Reset and strobe on the same edge: sample dropped
    v0 = n_valid;
    @(negedge i_clk);
    i_rst = 1'b1;
    i_sample = 1'b1;
    i_100 = enc(7); i_010 = enc(0); i_001 = enc(0);
    @(negedge i_clk);
    i_rst = 1'b0;
    i_sample = 1'b0;
    strobe(800);
    check("simul_reprime", n_valid, v0);
    strobe(805);
    check("simul_delta", last_delta, 5);
    check("simul_count", last_count, 805);

    idle(3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ring_count_decode.md
# ring_count_decode

Decoder and rate extractor for the three-digit Johnson-coded ring counter value after it has been captured into the `i_clk` domain. Decodes the three 5-bit digit codes (hundreds, tens, ones) to a binary count, computes the modulo-1000 advance since the previous sample, and averages that advance over a power-of-two window. It sits between the capture stage and the LED scan/readout logic, and gives the ring frequency as counts per sample period.

## Interface
- `pAVG_LOG2`, default 2: log2 of the averaging window in deltas. Legal range is 0..6.
- `i_clk` input, 1 bit: system clock. All logic is on the rising edge.
- `i_rst` input, 1 bit: one clock; reset is synchronous and active-high.
- `i_sample` input, 1 bit: one-cycle strobe. The digits are taken on the edge where it is high.
- `i_100` input, 5 bits: hundreds digit, Johnson code.
- `i_010` input, 5 bits: tens digit, Johnson code.
- `i_001` input, 5 bits: ones digit, Johnson code.
- `o_valid` output, 1 bit: one-cycle pulse. `o_count`, `o_delta` and `o_err` are valid while it is high.
- `o_count` output, 10 bits: decoded binary count, 0..999.
- `o_delta` output, 10 bits: (current − previous) mod 1000.
- `o_err` output, 1 bit: an illegal digit code was seen. Asserted only together with `o_valid`.
- `o_avg_valid` output, 1 bit: one-cycle pulse when the averaging window completes.
- `o_avg` output, 10 bits: windowed mean of `o_delta`, truncated.

## Operation
- **Digit code table** (index 0 through 9, in order): 00000, 00001, 00011, 00111, 01111, 11111, 11110, 11100, 11000, 10000.
  - Any other 5-bit value is illegal.
- **Pipeline**, fully pipelined, one sample accepted per cycle, no backpressure:
  - S1: register the three digits and the strobe.
  - S2: table decode to three 4-bit BCD values, plus a per-digit illegal flag.
  - S3: count = 100·h + 10·t + o. Use shift-add; no multiplier is required. Width is 10 bits.
  - S4: compute delta. Drive the outputs.
- **Delta:**
  - If cur ≥ prev, delta = cur − prev.
  - Otherwise delta = cur + 1000 − prev.
  - Use an 11-bit intermediate. The result is always 0..999.
- **Prime flag:**
  - Cleared by reset, and cleared by any error sample.
  - When the flag is clear, a legal sample loads prev, sets the flag, and produces no `o_valid`.
  - When the flag is set, a legal sample drives `o_valid`=1, `o_err`=0, `o_count`=cur, `o_delta`=delta, and then sets prev=cur.
- **Error sample** (any digit illegal):
  - Outputs: `o_valid`=1, `o_err`=1, `o_count`=0, `o_delta`=0.
  - The prime flag clears.
  - The partial averaging window is discarded: accumulator and window counter go to 0.
  - The error sample does not count toward the window.
- **Averaging:**
  - Accumulator width is 10+`pAVG_LOG2`.
  - Each legal, non-prime delta is added, and the window counter increments.
  - When the counter reaches 2^`pAVG_LOG2`:
    - `o_avg` = (acc + delta) >> `pAVG_LOG2`.
    - `o_avg_valid` pulses on the same edge as that delta's `o_valid`.
    - Accumulator and counter clear on that edge.
  - With `pAVG_LOG2`=0, `o_avg` equals `o_delta` on every legal, non-prime sample.
- `o_avg` holds its value between window completions.
- Samples that are not strobed have no effect. Pipeline stages without a strobe carry only a cleared valid bit.

## Timing
- **Latency:** with `i_sample` high at edge N, `o_valid` (or no output, for a prime sample) is registered at edge N+3. It is high for exactly one cycle unless the next sample follows back-to-back.
- **Back-to-back:** strobes on consecutive cycles produce `o_valid` on consecutive cycles. prev and the accumulator update in S4, so there is no hazard.
- **Reset values** (all outputs and state):
  - `o_valid`=0, `o_count`=0, `o_delta`=0, `o_err`=0, `o_avg_valid`=0, `o_avg`=0.
  - Prime flag clear, prev=0, accumulator=0, window counter=0.
  - All pipeline valid bits are 0.
- **Reset mid-operation:** samples in flight are dropped and produce no output. The first sample after reset primes.
- **Simultaneous reset and strobe:** reset wins, and the sample is dropped.
- **Wrap-around:** prev=998 and cur=5 gives delta=7. cur equal to prev gives delta=0, which is legal and is counted in the average.

## Test plan
- **Prime:**
  - After reset, strobe 123 (h=00001, t=00011, o=00111): no `o_valid`.
  - Then strobe 130: `o_valid` at N+3, `o_count`=130, `o_delta`=7, `o_err`=0.
- **Wrap:**
  - Strobe 998, then 5.
  - Required: `o_delta`=7, `o_count`=5.
  - Strobe 5 again: `o_delta`=0.
- **Error:**
  - From the primed state, strobe with ones digit 01010.
  - Required: `o_valid`=1, `o_err`=1, `o_delta`=0.
  - The next legal sample produces no `o_valid` (re-prime). The one after it gives the correct delta.
- **Average** (`pAVG_LOG2`=2):
  - Deltas 10, 11, 12, 14.
  - Required: `o_avg_valid` on the 4th `o_valid`, `o_avg`=11 (47>>2).
  - An error after 2 deltas restarts the window.
- **Throughput:**
  - Strobe every cycle with counts 0, 1, 2, …, 20.
  - Required: 20 consecutive `o_valid` cycles, each with `o_delta`=1. `o_avg_valid` every 4th cycle, with `o_avg`=1.
- **Reset mid-pipeline:**
  - Assert `i_rst` one cycle after a strobe.
  - Required: no `o_valid` from the dropped sample, all outputs 0, and the next strobe primes.
